// File: rtl/gray4_decoder.sv
`default_nettype none
// ============================================================================
// Module      : gray4_decoder
// Description : Gray-to-binary nibble decoder with BCD range flag, a 2-entry
//               valid/ready output buffer and saturating word/error counters.
// Revision    : 1.0 - initial release
// ============================================================================

module gray4_decoder #(
    parameter int STRICT = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_bin,
    output logic             out_bcd_err,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       c_bcd_max = 4'd9;

    state_t           state_q, state_d;
    logic [4:0]       head_q, head_d;      // {bin, err} of the entry on the output
    logic [4:0]       tail_q, tail_d;      // second entry, only meaningful in FULL
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0]       w_bin;
    logic             w_err;
    logic [4:0]       w_entry;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_bin[3] = in_gray[3];
        w_bin[2] = ^in_gray[3:2];
        w_bin[1] = ^in_gray[3:1];
        w_bin[0] = ^in_gray[3:0];
    end

    assign w_err    = (w_bin > c_bcd_max);
    assign w_entry  = {w_bin, w_err};
    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_push   = w_accept && !((STRICT != 0) && w_err);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    head_d  = w_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && !w_pop) begin
                    tail_d  = w_entry;
                    state_d = ST_FULL;
                end else if (!w_push && w_pop) begin
                    state_d = ST_EMPTY;
                end else if (w_push && w_pop) begin
                    head_d  = w_entry;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so a push cannot coincide with the pop
                if (w_pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clear_counts) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (w_accept) begin
            if (word_cnt_q != c_cnt_max) begin
                word_cnt_d = word_cnt_q + c_cnt_one;
            end
            if (w_err && (err_cnt_q != c_cnt_max)) begin
                err_cnt_d = err_cnt_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready    = (state_q != ST_FULL);
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_bin     = head_q[4:1];
    assign out_bcd_err = head_q[0];
    assign word_count  = word_cnt_q;
    assign err_count   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gray4_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray4_decoder
// Description : Directed bench for gray4_decoder, lenient and strict variants.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_gray4_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready, out_bcd_err, clear_counts;
    logic [3:0] in_gray, out_bin;
    logic [7:0] word_count, err_count;
    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_bcd_err, s_clear_counts;
    logic [3:0] s_in_gray, s_out_bin;
    logic [7:0] s_word_count, s_err_count;

    int n_vec;
    int n_err;

    gray4_decoder #(.STRICT(0), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bin(out_bin), .out_bcd_err(out_bcd_err),
        .clear_counts(clear_counts),
        .word_count(word_count), .err_count(err_count)
    );

    gray4_decoder #(.STRICT(1), .CNT_W(8)) u_dut_strict (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_gray(s_in_gray),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_bin(s_out_bin), .out_bcd_err(s_out_bcd_err),
        .clear_counts(s_clear_counts),
        .word_count(s_word_count), .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; out_ready = 1'b0; clear_counts = 1'b0; in_gray = 4'd0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_clear_counts = 1'b0; s_in_gray = 4'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        n_vec++; if (out_bin !== 4'd0) begin n_err++; $display("FAIL reset_out_bin got %0d exp 0", out_bin); end
        n_vec++; if (out_bcd_err !== 1'b0) begin n_err++; $display("FAIL reset_bcd_err got %0b exp 0", out_bcd_err); end
        n_vec++; if (word_count !== 8'd0) begin n_err++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
        n_vec++; if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_strict_in_ready got %0b exp 1", s_in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_gray = 4'b0110;
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b exp 1", out_valid); end
        n_vec++; if (out_bin !== 4'd4) begin n_err++; $display("FAIL single_bin got %0d exp 4", out_bin); end
        n_vec++; if (out_bcd_err !== 1'b0) begin n_err++; $display("FAIL single_err got %0b exp 0", out_bcd_err); end
        n_vec++; if (word_count !== 8'd1) begin n_err++; $display("FAIL single_word_count got %0d exp 1", word_count); end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL single_err_count got %0d exp 0", err_count); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_boundary();
        logic [3:0] gray_v [3];
        logic [3:0] bin_v  [3];
        logic       err_v  [3];
        gray_v = '{4'b1101, 4'b1111, 4'b1000};
        bin_v  = '{4'd9, 4'd10, 4'd15};
        err_v  = '{1'b0, 1'b1, 1'b1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_gray = gray_v[i];
            step();
            n_vec++; if (out_bin !== bin_v[i] || out_valid !== 1'b1) begin n_err++; $display("FAIL boundary_bin[%0d] got %0d/v%0b exp %0d/v1", i, out_bin, out_valid, bin_v[i]); end
            n_vec++; if (out_bcd_err !== err_v[i]) begin n_err++; $display("FAIL boundary_err[%0d] got %0b exp %0b", i, out_bcd_err, err_v[i]); end
        end
        in_valid = 1'b0;
        n_vec++; if (word_count !== 8'd3) begin n_err++; $display("FAIL boundary_word_count got %0d exp 3", word_count); end
        n_vec++; if (err_count !== 8'd2) begin n_err++; $display("FAIL boundary_err_count got %0d exp 2", err_count); end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_gray = 4'b0000;
        step();
        n_vec++; if (in_ready !== 1'b1 || out_bin !== 4'd0) begin n_err++; $display("FAIL bp_first got rdy%0b/%0d exp rdy1/0", in_ready, out_bin); end
        in_gray = 4'b0101;
        step();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %0b exp 0", in_ready); end
        in_gray = 4'b0001;
        step();
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bin !== 4'd0) begin n_err++; $display("FAIL bp_hold got rdy%0b v%0b %0d exp rdy0 v1 0", in_ready, out_valid, out_bin); end
        n_vec++; if (word_count !== 8'd2) begin n_err++; $display("FAIL bp_word_count_held got %0d exp 2", word_count); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_bin !== 4'd6 || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_second got %0d v%0b rdy%0b exp 6 v1 rdy1", out_bin, out_valid, in_ready); end
        n_vec++; if (word_count !== 8'd2) begin n_err++; $display("FAIL bp_no_accept_when_full got %0d exp 2", word_count); end
        step();
        in_valid = 1'b0;
        n_vec++; if (out_bin !== 4'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_third got %0d v%0b exp 1 v1", out_bin, out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %0b exp 0", out_valid); end
        n_vec++; if (word_count !== 8'd3) begin n_err++; $display("FAIL bp_word_count got %0d exp 3", word_count); end
    endtask

    task automatic test_strict();
        do_reset();
        s_out_ready = 1'b1;
        s_in_valid = 1'b1; s_in_gray = 4'b1111;
        step();
        n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL strict_drop got v%0b exp 0", s_out_valid); end
        s_in_gray = 4'b0001;
        step();
        s_in_valid = 1'b0;
        n_vec++; if (s_out_valid !== 1'b1 || s_out_bin !== 4'd1 || s_out_bcd_err !== 1'b0) begin n_err++; $display("FAIL strict_emit got v%0b %0d e%0b exp v1 1 e0", s_out_valid, s_out_bin, s_out_bcd_err); end
        n_vec++; if (s_word_count !== 8'd2) begin n_err++; $display("FAIL strict_word_count got %0d exp 2", s_word_count); end
        n_vec++; if (s_err_count !== 8'd1) begin n_err++; $display("FAIL strict_err_count got %0d exp 1", s_err_count); end
        step();
        n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL strict_single_emit got v%0b exp 0", s_out_valid); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_gray = 4'b1000;
        for (int i = 0; i < 254; i++) step();
        n_vec++; if (word_count !== 8'd254) begin n_err++; $display("FAIL sat_pre_word got %0d exp 254", word_count); end
        for (int i = 0; i < 46; i++) step();
        n_vec++; if (word_count !== 8'd255) begin n_err++; $display("FAIL sat_word got %0d exp 255", word_count); end
        n_vec++; if (err_count !== 8'd255) begin n_err++; $display("FAIL sat_err got %0d exp 255", err_count); end
        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0; in_valid = 1'b0;
        n_vec++; if (word_count !== 8'd0) begin n_err++; $display("FAIL clear_word got %0d exp 0", word_count); end
        n_vec++; if (err_count !== 8'd0) begin n_err++; $display("FAIL clear_err got %0d exp 0", err_count); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_gray = 4'b0111;
        step();
        step();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_full got rdy%0b exp 0", in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_flush got v%0b rdy%0b exp v0 rdy1", out_valid, in_ready); end
        n_vec++; if (word_count !== 8'd0 || err_count !== 8'd0) begin n_err++; $display("FAIL mid_counts got %0d/%0d exp 0/0", word_count, err_count); end
        out_ready = 1'b1; in_valid = 1'b1; in_gray = 4'b0011;
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_bin !== 4'd2) begin n_err++; $display("FAIL mid_next got v%0b %0d exp v1 2", out_valid, out_bin); end
        n_vec++; if (word_count !== 8'd1) begin n_err++; $display("FAIL mid_next_count got %0d exp 1", word_count); end
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; clear_counts = 1'b0; in_gray = 4'd0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_clear_counts = 1'b0; s_in_gray = 4'd0;
        test_reset();
        test_single();
        test_boundary();
        test_backpressure();
        test_strict();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gray4_decoder.md
# gray4_decoder

Bit-parallel Gray-to-binary decoder with valid/ready handshakes on both sides and a 2-entry output buffer. It is the receive-side inverse of the team's 4-bit combinational code converter (inputs w,x,y,z). It recovers the binary nibble from a Gray word, flags results outside the BCD range 0–9, and keeps saturating word and error counters. Downstream BCD display logic consumes its output.

## Interface
Parameters:
- STRICT, 0: 1 = words with BCD error are counted but not pushed to the output buffer; 0 = pushed with `out_bcd_err` set.
- CNT_W, 8: width of both counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  decoder can accept a word this cycle.
- in_gray  input  4  Gray word; bit 3 = w (MSB), bit 0 = z.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  downstream accepts head this cycle.
- out_bin  output  4  decoded binary of buffer head.
- out_bcd_err  output  1  head value > 9.
- clear_counts  input  1  synchronous clear of both counters.
- word_count  output  CNT_W  accepted words, saturating.
- err_count  output  CNT_W  accepted words with BCD error, saturating.

## Operation
- Accept: `in_valid && in_ready` at a rising edge.
- Decode (combinational on `in_gray`): b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0. `err = (b > 9)`.
- Every accepted word increments `word_count`. If `err` is set, it also increments `err_count`. Both counters saturate at 2^CNT_W−1 and never wrap.
- `clear_counts` zeroes both counters. It takes priority over an increment in the same cycle.
- Push: an accepted word is written to the buffer as {b, err}. With STRICT=1 and err=1 the word is accepted and counted but not written.
- Buffer is a 2-entry FIFO with states EMPTY, ONE, FULL:
  - EMPTY --push--> ONE.
  - ONE --push, no pop--> FULL; ONE --pop, no push--> EMPTY; ONE --push and pop--> ONE, new word becomes head.
  - FULL --pop--> ONE.
- Pop: `out_valid && out_ready` at a rising edge.
- `in_ready = (state != FULL)`. It is registered-state-derived only, so there is no combinational path from `out_ready` to `in_ready`. In FULL with `out_ready=1`, `in_ready` stays 0 that cycle.
- `out_valid = (state != EMPTY)`. `out_bin`/`out_bcd_err` show the head entry. They are held stable while `out_valid && !out_ready`.
- `in_gray` is ignored when `in_valid=0` or `in_ready=0`.

## Timing
- Reset values: state EMPTY, `out_valid=0`, `in_ready=1`, `out_bin=0`, `out_bcd_err=0`, `word_count=0`, `err_count=0`.
- Reset mid-operation discards buffered words. A handshake in the reset cycle is not accepted or counted.
- Latency: a word accepted at edge N into EMPTY is presented with `out_valid=1` in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle sustained when `out_ready` is held 1.
- Counters update at the same edge that accepts the word and are visible the next cycle.
- Simultaneous push and pop in ONE keeps the count at one and the head becomes the new word.
- With STRICT=1, a dropped word leaves the state unchanged but still counts.

## Test plan
- Reset then single word: in_gray=4'b0110 with out_ready=1 → next cycle out_valid=1, out_bin=4'd4, out_bcd_err=0, word_count=1, err_count=0.
- Boundary and error (STRICT=0): stream 4'b1101, 4'b1111, 4'b1000 → outputs 9/err0, 10/err1, 15/err1; err_count=2, word_count=3.
- Backpressure: out_ready=0, offer 4'b0000, 4'b0101, 4'b0001 → first two accepted, in_ready=0 after the second; the third is held. Then out_ready=1 → outputs 0, 6, 1 in order, none lost or duplicated.
- STRICT=1: send 4'b1111 then 4'b0001 → only out_bin=1 emitted; word_count=2, err_count=1.
- Saturation/clear: 300 accepted words of 4'b1000 → both counters hold 255. Assert clear_counts together with an accepted word → both counters read 0 next cycle.
- Reset mid-stream: buffer FULL, assert rst one cycle → out_valid=0, in_ready=1, counters 0; the next word decodes normally.
